// File: rtl/button_encoder_pkg.sv
// rtl/button_encoder_pkg.sv - shared constants, encoder states and helpers for the button front end
package button_encoder_pkg;

  localparam int COLOR_W    = 2;
  localparam int NUM_COLORS = 4;

  typedef enum logic [1:0] {
    ENC_IDLE_S    = 2'd0,
    ENC_ACTIVE_S  = 2'd1,
    ENC_LOCKOUT_S = 2'd2
  } enc_state_e;

  // Index of the highest set bit; only meaningful when exactly one bit is set.
  function automatic logic [COLOR_W-1:0] color_index(input logic [NUM_COLORS-1:0] btn);
    logic [COLOR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_COLORS; i++) begin
      if (btn[i]) idx = COLOR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_encoder_debounce.sv
// rtl/button_encoder_debounce.sv - one synchronizer plus debounce counter lane
module button_encoder_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic stb
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_0;
  logic          sync_1;
  logic [CW-1:0] cnt;

  // Any sample agreeing with the stable level restarts the count, so bounces never accumulate.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_0 <= 1'b0;
      sync_1 <= 1'b0;
      cnt    <= '0;
      stb    <= 1'b0;
    end else begin
      sync_0 <= raw;
      sync_1 <= sync_0;
      if (sync_1 != stb) begin
        if (cnt == CNT_MAX) begin
          stb <= ~stb;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/button_encoder.sv
// rtl/button_encoder.sv - debounces four colour buttons and start, encodes one accepted press into IN/IN_VALID
module button_encoder
  import button_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [3:0]         BTN,
  input  logic               BTN_START,
  output logic [COLOR_W-1:0] IN,
  output logic               IN_VALID,
  output logic               START_GAME
);

  logic [4:0]            raw_lanes;
  logic [4:0]            stb;
  logic [NUM_COLORS-1:0] color_stb;
  enc_state_e            state;

  assign raw_lanes = {BTN_START, BTN};
  assign color_stb = stb[NUM_COLORS-1:0];

  for (genvar g = 0; g < 5; g++) begin : g_lane
    button_encoder_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .CLK(CLK),
      .RST(RST),
      .raw(raw_lanes[g]),
      .stb(stb[g])
    );
  end

  // A release with other buttons still down goes through lockout, which forces an idle gap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ENC_IDLE_S;
      IN         <= '0;
      IN_VALID   <= 1'b0;
      START_GAME <= 1'b0;
    end else begin
      START_GAME <= stb[4];
      case (state)
        ENC_IDLE_S: begin
          IN_VALID <= 1'b0;
          if ($countones(color_stb) == 1) begin
            IN       <= color_index(color_stb);
            IN_VALID <= 1'b1;
            state    <= ENC_ACTIVE_S;
          end else if (color_stb != '0) begin
            state <= ENC_LOCKOUT_S;
          end
        end
        ENC_ACTIVE_S: begin
          if (!color_stb[IN]) begin
            IN_VALID <= 1'b0;
            state    <= (color_stb != '0) ? ENC_LOCKOUT_S : ENC_IDLE_S;
          end
        end
        ENC_LOCKOUT_S: begin
          IN_VALID <= 1'b0;
          if (color_stb == '0) state <= ENC_IDLE_S;
        end
        default: begin
          IN_VALID <= 1'b0;
          state    <= ENC_IDLE_S;
        end
      endcase
    end
  end

endmodule
